cpu_step_ctrl: RTL

//   Run/step/breakpoint sequencer for the pipelined CPU. Sits between the debounced

---
 rtl/cpu_step_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer that gates the CPU clock-enable.
// Drives free-run, key-paced single-step, or a halt when the IF-stage PC reaches a breakpoint.
module cpu_step_ctrl #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic             sysclk_i,
    input  logic             reset_ni,
    input  logic             key_step_i,
    input  logic             run_sw_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             cpu_en_o,
    output logic             halted_o,
    output logic             bp_hit_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] step_cnt_o
);

    localparam logic [1:0] StHalt  = 2'b00;
    localparam logic [1:0] StRun   = 2'b01;
    localparam logic [1:0] StStep  = 2'b10;
    localparam logic [1:0] StBreak = 2'b11;

    localparam logic [7:0] StepLoad = 8'(STEP_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       remain_q, remain_d;
    logic             key_q;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    logic key_rise;
    logic bp_match;
    logic cpu_en;
    logic unused_addr_lsbs;

    // Word-aligned compare: the byte-offset bits never participate.
    assign unused_addr_lsbs = ^{pc_i[1:0], bp_addr_i[1:0]};
    assign bp_match         = bp_en_i & (pc_i[PC_W-1:2] == bp_addr_i[PC_W-1:2]);
    assign key_rise         = key_step_i & ~key_q;

    // The instruction sitting on the breakpoint is never advanced in free-run.
    assign cpu_en = ((state_q == StRun) & ~bp_match) | (state_q == StStep);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            StHalt: begin
                if (run_sw_i) begin
                    state_d = StRun;
                end else if (key_rise) begin
                    state_d  = StStep;
                    remain_d = StepLoad;
                end
            end
            StRun: begin
                if (!run_sw_i) begin
                    state_d = StHalt;
                end else if (bp_match) begin
                    state_d = StBreak;
                end
            end
            StStep: begin
                if (remain_q == 8'd0) begin
                    state_d = StHalt;
                end else begin
                    remain_d = remain_q - 8'd1;
                end
            end
            default: begin
                if (!run_sw_i) begin
                    state_d = StHalt;
                end else if (key_rise) begin
                    state_d  = StStep;
                    remain_d = StepLoad;
                end
            end
        endcase
    end

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (cpu_en && (step_cnt_q != {CNT_W{1'b1}})) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!reset_ni) begin
            state_q    <= StHalt;
            remain_q   <= 8'd0;
            key_q      <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            key_q      <= key_step_i;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign cpu_en_o   = cpu_en;
    assign state_o    = state_q;
    assign halted_o   = (state_q == StHalt) | (state_q == StBreak);
    assign bp_hit_o   = (state_q == StBreak);
    assign step_cnt_o = step_cnt_q;

endmodule
